nibble_add_sched: RTL
=====================

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; NIBBLES SHALL be at least 1.
REQ-002 Port: clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  W  requester 0 operands.
REQ-007 Port: req0_cin  input  1  requester 0 carry-in.
REQ-008 Port: req1_valid, req1_ready, req1_a, req1_b, req1_cin SHALL be identical to REQ-004..007 for requester 1.
REQ-009 Port: resp_valid  output  1  result available.
REQ-010 Port: resp_ready  input  1  consumer accepts result.
REQ-011 Port: resp_id  output  1  requester index owning the result.
REQ-012 Port: resp_sum  output  W  sum result.
REQ-013 Port: resp_cout  output  1  carry-out of the most significant slice.
REQ-014 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block SHALL contain exactly one 4-bit ripple-carry add slice and SHALL time-share it across nibbles and requesters.
REQ-016 FSM states: IDLE, ADD, DONE; all registered outputs are reset to IDLE values.
REQ-017 IDLE: the grant is computed combinationally; reqN_ready SHALL be high only for the granted requester, only when its valid is high, and only in IDLE.
REQ-018 Arbitration is round-robin: if one valid, grant it; if both valid, grant the requester not granted last; last_grant SHALL be 1 out of reset so that requester 0 wins the first tie.
REQ-019 On handshake (valid & ready), capture a, b, cin, and id; set nibble index to 0 and carry to cin; update last_grant; go to ADD.
REQ-020 ADD: each cycle, add nibble i of a and b with the carry register; write the 4-bit sum into nibble i of resp_sum; store the carry-out; increment i.
REQ-021 After nibble NIBBLES-1 is written, transition to DONE; resp_cout SHALL equal the final carry.
REQ-022 Latency: resp_valid SHALL rise exactly NIBBLES clock edges after the accepting edge (4 for the default).
REQ-023 DONE: resp_valid=1; resp_sum, resp_cout, resp_id are stable until resp_ready is sampled high; then go to IDLE.
REQ-024 There is no back-to-back overlap: a new request is accepted no earlier than the cycle after the DONE handshake.
REQ-025 Request inputs changing after acceptance SHALL NOT affect the result in progress.
REQ-026 Arithmetic is modulo 2^W; overflow is signalled only through resp_cout.

Reset
REQ-027 Asserting rst at any time, including mid-ADD or in DONE, SHALL immediately force IDLE, resp_valid=0, reqN_ready=0, busy=0, resp_sum=0, resp_cout=0, resp_id=0, nibble index=0, carry=0, and last_grant=1; any in-flight operation is discarded.
REQ-028 After rst deasserts, the first rising edge SHALL follow the normal IDLE rules.

Verification
REQ-029 Requester 0 issues a=0xFFFF, b=0x0001, cin=0 -> resp_valid rises 4 cycles after acceptance with sum=0x0000, cout=1, id=0.
REQ-030 Requester 1 issues a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, id=1.
REQ-031 Both valid continuously from reset, with resp_ready=1 -> grants alternate 0,1,0,1; the first result has id=0.
REQ-032 Hold resp_ready=0 for 5 cycles in DONE -> resp_valid and outputs are held, reqN_ready stays 0; complete the handshake, then accept the next request.
REQ-033 Assert rst during the second ADD cycle -> all outputs are 0 asynchronously; a subsequent request for 0x00FF+0x0001 gives sum=0x0100, cout=0.
REQ-034 Change req0_a/b on the cycle after acceptance -> the result reflects the captured operands only.

Source files
------------

// File: rtl/nibble_add_sched.sv
// -----------------------------------------------------------------------------
// nibble_add_sched
//
// Two requesters share one 4-bit ripple-carry add slice. A granted operation
// is added one nibble per clock, least significant nibble first. The result
// is held in DONE until the consumer takes it.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A valid that is not accepted is simply
// sampled again next cycle. The ready outputs are combinational; they are
// only ever high in IDLE, and never while rst is asserted.
//
// Parameters
//   NIBBLES     number of 4-bit slices per operand (>= 1); W = 4*NIBBLES
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   req0_valid / req0_ready   requester 0 handshake
//   req0_a, req0_b, req0_cin  requester 0 operands and carry-in
//   req1_*                    same for requester 1
//   resp_valid / resp_ready   result handshake
//   resp_id                   requester that owns the result
//   resp_sum, resp_cout       W-bit sum and carry-out of the top nibble
//   busy                      high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module nibble_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic [4*NIBBLES-1:0]   resp_sum,
    output logic                   resp_cout,
    output logic                   busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            last_grant;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            id_q;

    logic            grant_id;
    logic            accept;
    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      nib_sum;
    logic            nib_cout;
    logic            rc;

    // Round-robin: a lone valid wins; on a tie the requester not granted
    // last time wins. last_grant resets to 1 so requester 0 wins the first tie.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // rst gates ready directly so the handshake is dead while reset is held,
    // independent of the clock.
    assign req0_ready = (state == IDLE) && !rst && req0_valid && !grant_id;
    assign req1_ready = (state == IDLE) && !rst && req1_valid &&  grant_id;
    assign accept     = req0_ready | req1_ready;

    // Select the current nibble and run it through the single ripple slice.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
                a_nib = a_q[n*4 +: 4];
                b_nib = b_q[n*4 +: 4];
            end
        end
        rc = carry;
        nib_sum = '0;
        for (int k = 0; k < 4; k++) begin
            nib_sum[k] = a_nib[k] ^ b_nib[k] ^ rc;
            rc         = (a_nib[k] & b_nib[k]) | (rc & (a_nib[k] ^ b_nib[k]));
        end
        nib_cout = rc;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)            state_next = ADD;
            ADD:     if (idx == LAST_IDX)   state_next = DONE;
            DONE:    if (resp_ready)        state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            last_grant <= 1'b1;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            id_q       <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a_q        <= grant_id ? req1_a   : req0_a;
                b_q        <= grant_id ? req1_b   : req0_b;
                carry      <= grant_id ? req1_cin : req0_cin;
                idx        <= '0;
                last_grant <= grant_id;
                id_q       <= grant_id;
                sum_q      <= '0;
                cout_q     <= 1'b0;
            end
        end else if (state == ADD) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx == IW'(n)) begin
                    sum_q[n*4 +: 4] <= nib_sum;
                end
            end
            carry <= nib_cout;
            if (idx == LAST_IDX) begin
                idx    <= '0;
                cout_q <= nib_cout;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_sum   = sum_q;
    assign resp_cout  = cout_q;
    assign resp_id    = id_q;

endmodule
